// File: rtl/router_port_ctrl.sv
// Router output-port controller: header address decode, per-port FIFO write
// steering, full-flag selection, and per-port stall timeout that flushes an
// output FIFO whose data sits valid but unread for TIMEOUT consecutive cycles.
module router_port_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       clr_flags,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2,
    output logic [2:0] timeout_flag
);

    // Terminal count: the TIMEOUT-th qualifying cycle sees the counter at TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]            addr_q, addr_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            soft_reset_q, soft_reset_d;
    logic [2:0]            timeout_flag_q, timeout_flag_d;

    logic [2:0] vld;
    logic [2:0] read_enb;

    // Data-valid is simply "FIFO not empty"; it does not depend on addressing.
    assign vld      = ~{empty_2, empty_1, empty_0};
    assign read_enb = {read_enb_2, read_enb_1, read_enb_0};

    assign vld_out_0    = vld[0];
    assign vld_out_1    = vld[1];
    assign vld_out_2    = vld[2];
    assign soft_reset_0 = soft_reset_q[0];
    assign soft_reset_1 = soft_reset_q[1];
    assign soft_reset_2 = soft_reset_q[2];
    assign timeout_flag = timeout_flag_q;

    // Steer the write strobe and pick the full flag of the latched port; address 11 is dead.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr_q)
            2'b00: begin
                write_enb[0] = write_enb_reg;
                fifo_full    = full_0;
            end
            2'b01: begin
                write_enb[1] = write_enb_reg;
                fifo_full    = full_1;
            end
            2'b10: begin
                write_enb[2] = write_enb_reg;
                fifo_full    = full_2;
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    // Next address, per-port stall counters, flush pulses and sticky flags.
    always_comb begin
        addr_d         = detect_add ? data_in : addr_q;
        cnt_d          = cnt_q;
        soft_reset_d   = 3'b000;
        timeout_flag_d = timeout_flag_q;
        for (int n = 0; n < 3; n++) begin
            if (!vld[n] || read_enb[n]) begin
                // Nothing waiting, or downstream is draining: the stall is over.
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CNT_LAST) begin
                // Stalled long enough: flush and start timing the next window.
                cnt_d[n]        = '0;
                soft_reset_d[n] = 1'b1;
            end else begin
                cnt_d[n] = cnt_q[n] + CNT_ONE;
            end
            // A new timeout outranks a clear arriving on the same edge.
            if (soft_reset_d[n]) begin
                timeout_flag_d[n] = 1'b1;
            end else if (clr_flags) begin
                timeout_flag_d[n] = 1'b0;
            end
        end
    end

    // State register with synchronous active-low reset overriding every update.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst) begin
            addr_q         <= 2'b00;
            cnt_q          <= '0;
            soft_reset_q   <= 3'b000;
            timeout_flag_q <= 3'b000;
        end else begin
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            soft_reset_q   <= soft_reset_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

endmodule

// File: tb/tb_router_port_ctrl.sv
// Self-checking bench for router_port_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// streak-based behavioural model.
module tb_router_port_ctrl;

    localparam int TIMEOUT = 30;
    localparam int CNT_W   = 5;

    logic       clk;
    logic       rst;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [2:0] empty;
    logic [2:0] full;
    logic [2:0] read_enb;
    logic       clr_flags;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic [2:0] timeout_flag;

    int pass_cnt  = 0;
    int total_cnt = 0;

    router_port_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .detect_add   (detect_add),
        .data_in      (data_in),
        .write_enb_reg(write_enb_reg),
        .empty_0      (empty[0]),
        .empty_1      (empty[1]),
        .empty_2      (empty[2]),
        .full_0       (full[0]),
        .full_1       (full[1]),
        .full_2       (full[2]),
        .read_enb_0   (read_enb[0]),
        .read_enb_1   (read_enb[1]),
        .read_enb_2   (read_enb[2]),
        .clr_flags    (clr_flags),
        .write_enb    (write_enb),
        .fifo_full    (fifo_full),
        .vld_out_0    (vld_out_0),
        .vld_out_1    (vld_out_1),
        .vld_out_2    (vld_out_2),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2),
        .timeout_flag (timeout_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each port tracks the length of its current valid-and-unread streak;
    // a flush is due whenever that streak is a nonzero multiple of TIMEOUT.
    logic [1:0] m_addr;
    int         m_streak [3];
    logic [2:0] m_sr;
    logic [2:0] m_flag;
    logic       m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_addr  <= 2'b00;
            m_sr    <= 3'b000;
            m_flag  <= 3'b000;
            m_valid <= 1'b1;
            for (int n = 0; n < 3; n++) m_streak[n] <= 0;
        end else begin
            if (detect_add) m_addr <= data_in;
            for (int n = 0; n < 3; n++) begin
                if (!empty[n] && !read_enb[n]) begin
                    m_streak[n] <= m_streak[n] + 1;
                    m_sr[n]     <= ((m_streak[n] + 1) % TIMEOUT) == 0;
                    m_flag[n]   <= (((m_streak[n] + 1) % TIMEOUT) == 0) || (m_flag[n] && !clr_flags);
                end else begin
                    m_streak[n] <= 0;
                    m_sr[n]     <= 1'b0;
                    m_flag[n]   <= m_flag[n] && !clr_flags;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("write_enb", {29'd0, write_enb},
                  (write_enb_reg && m_addr != 2'b11) ? (32'd1 << m_addr) : 32'd0);
            check("fifo_full", {31'd0, fifo_full},
                  (m_addr == 2'b11) ? 32'd0 : {31'd0, full[m_addr]});
            check("vld_out", {29'd0, vld_out_2, vld_out_1, vld_out_0}, {29'd0, ~empty});
            check("soft_reset", {29'd0, soft_reset_2, soft_reset_1, soft_reset_0}, {29'd0, m_sr});
            check("timeout_flag", {29'd0, timeout_flag}, {29'd0, m_flag});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        detect_add    = 1'b0;
        data_in       = 2'b00;
        write_enb_reg = 1'b0;
        empty         = 3'b111;
        full          = 3'b000;
        read_enb      = 3'b000;
        clr_flags     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;

        // Reset state.
        check("rst_write_enb", {29'd0, write_enb}, 32'h0);
        check("rst_soft_reset", {29'd0, soft_reset_2, soft_reset_1, soft_reset_0}, 32'h0);
        check("rst_timeout_flag", {29'd0, timeout_flag}, 32'h0);
        full = 3'b001;
        write_enb_reg = 1'b1;
        #1;
        check("rst_addr_port0_we", {29'd0, write_enb}, 32'h1);
        check("rst_fifo_full_is_full0", {31'd0, fifo_full}, 32'h1);
        empty = 3'b010;
        #1;
        check("vld_immediate", {29'd0, vld_out_2, vld_out_1, vld_out_0}, 32'h5);
        idle_inputs();
        tick();

        // Port 2 addressing; other full flags ignored.
        detect_add = 1'b1;
        data_in    = 2'b10;
        tick();
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b100;
        #1;
        check("p2_write_enb", {29'd0, write_enb}, 32'h4);
        check("p2_fifo_full", {31'd0, fifo_full}, 32'h1);
        full = 3'b011;
        #1;
        check("p2_full_others_ignored", {31'd0, fifo_full}, 32'h0);
        tick();

        // Invalid address 11.
        detect_add = 1'b1;
        data_in    = 2'b11;
        tick();
        detect_add = 1'b0;
        full       = 3'b111;
        #1;
        check("inv_write_enb", {29'd0, write_enb}, 32'h0);
        check("inv_fifo_full", {31'd0, fifo_full}, 32'h0);
        idle_inputs();
        tick();

        // Port 1 stalls 30 cycles: pulse right after the 30th edge.
        do_reset();
        empty[1] = 1'b0;
        repeat (TIMEOUT - 1) tick();
        check("p1_no_early_pulse", {31'd0, soft_reset_1}, 32'h0);
        tick();
        check("p1_pulse", {29'd0, soft_reset_2, soft_reset_1, soft_reset_0}, 32'h2);
        check("p1_flag", {29'd0, timeout_flag}, 32'h2);
        empty[1] = 1'b1;
        tick();
        check("p1_pulse_one_cycle", {31'd0, soft_reset_1}, 32'h0);
        check("p1_flag_sticky", {29'd0, timeout_flag}, 32'h2);

        // Read on the 30th cycle suppresses the pulse; persistent stall pulses twice.
        do_reset();
        empty[1] = 1'b0;
        repeat (TIMEOUT - 1) tick();
        read_enb[1] = 1'b1;
        tick();
        read_enb[1] = 1'b0;
        check("p1_read_suppress", {31'd0, soft_reset_1}, 32'h0);
        check("p1_read_no_flag", {29'd0, timeout_flag}, 32'h0);
        repeat (TIMEOUT - 1) tick();
        check("p1_after_read_early", {31'd0, soft_reset_1}, 32'h0);
        tick();
        check("p1_after_read_pulse", {31'd0, soft_reset_1}, 32'h1);
        repeat (TIMEOUT) tick();
        check("p1_repeat_pulse", {31'd0, soft_reset_1}, 32'h1);
        idle_inputs();
        tick();

        // Ports 0 and 2 together; clear on the pulse edge loses to the set.
        do_reset();
        empty = 3'b010;
        repeat (TIMEOUT - 1) tick();
        clr_flags = 1'b1;
        tick();
        check("p02_pulse", {29'd0, soft_reset_2, soft_reset_1, soft_reset_0}, 32'h5);
        check("p02_set_beats_clr", {29'd0, timeout_flag}, 32'h5);
        tick();
        check("p02_clr", {29'd0, timeout_flag}, 32'h0);
        idle_inputs();
        tick();

        // Reset mid-count restarts the full window.
        do_reset();
        empty[0] = 1'b0;
        repeat (20) tick();
        check("p0_mid_count", {31'd0, soft_reset_0}, 32'h0);
        do_reset();
        check("p0_rst_no_pulse", {31'd0, soft_reset_0}, 32'h0);
        repeat (TIMEOUT - 1) tick();
        check("p0_rst_restart_early", {31'd0, soft_reset_0}, 32'h0);
        tick();
        check("p0_rst_restart_pulse", {31'd0, soft_reset_0}, 32'h1);
        idle_inputs();
        tick();

        // Randomized traffic checked by the per-cycle compare.
        for (int c = 0; c < 4000; c++) begin
            rst           = ($urandom_range(0, 399) != 0);
            detect_add    = ($urandom_range(0, 7) == 0);
            data_in       = 2'($urandom_range(0, 3));
            write_enb_reg = 1'($urandom_range(0, 1));
            full          = 3'($urandom_range(0, 7));
            clr_flags     = ($urandom_range(0, 24) == 0);
            for (int n = 0; n < 3; n++) begin
                empty[n]    = ($urandom_range(0, 79) == 0);
                read_enb[n] = ($urandom_range(0, 59) == 0);
            end
            tick();
        end
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/router_port_ctrl.md
ROUTER_PORT_CTRL -- requirements
Module: router_port_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30: consecutive unread valid cycles before a port soft reset; legal range 2..2^CNT_W.
REQ-002 SHALL have parameter CNT_W, default 5: width of each per-port timeout counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 detect_add  input  1  header-decode strobe from the router FSM.
REQ-006 data_in  input  2  header address bits; 00/01/10 = port 0/1/2, 11 = invalid.
REQ-007 write_enb_reg  input  1  FSM request to write the current byte.
REQ-008 empty_0, empty_1, empty_2  input  1 each  output FIFO empty flags.
REQ-009 full_0, full_1, full_2  input  1 each  output FIFO full flags.
REQ-010 read_enb_0, read_enb_1, read_enb_2  input  1 each  downstream read strobes.
REQ-011 clr_flags  input  1  clears the sticky timeout flags.
REQ-012 write_enb  output  3  one-hot FIFO write enable; bit n = port n.
REQ-013 fifo_full  output  1  full flag of the addressed FIFO.
REQ-014 vld_out_0, vld_out_1, vld_out_2  output  1 each  port data-valid to downstream.
REQ-015 soft_reset_0, soft_reset_1, soft_reset_2  output  1 each  one-cycle FIFO flush pulse.
REQ-016 timeout_flag  output  3  sticky per-port timeout status.

Function
REQ-017 Address register addr_reg (2 bits) SHALL load data_in on any edge with detect_add=1, else hold.
REQ-018 write_enb SHALL be combinational: bit addr_reg set when write_enb_reg=1 and addr_reg!=11; all zero otherwise.
REQ-019 fifo_full SHALL be combinational: full_<addr_reg> for addr_reg 00/01/10; 0 for addr_reg=11.
REQ-020 vld_out_n SHALL be combinational ~empty_n, independent of addressing.
REQ-021 Each port n SHALL own a CNT_W-bit counter cnt_n, updated per edge in priority order:
  - vld_out_n=0 or read_enb_n=1: cnt_n <= 0, no pulse.
  - else cnt_n==TIMEOUT-1: cnt_n <= 0, soft_reset_n <= 1.
  - else cnt_n <= cnt_n+1.
REQ-022 soft_reset_n SHALL be registered; it SHALL be 0 on every edge not meeting the REQ-021 pulse condition, so each pulse lasts exactly one cycle.
REQ-023 Latency: soft_reset_n SHALL be high in the cycle after the TIMEOUT-th consecutive cycle with vld_out_n=1 and read_enb_n=0.
REQ-024 read_enb_n=1 in the same cycle cnt_n==TIMEOUT-1 SHALL suppress the pulse and clear cnt_n.
REQ-025 If the condition persists after a pulse, cnt_n SHALL restart from 0 and may pulse again after another TIMEOUT cycles.
REQ-026 The three ports SHALL be fully independent; simultaneous pulses on several ports are legal.
REQ-027 timeout_flag[n] SHALL set on the edge that raises soft_reset_n, clear on an edge with clr_flags=1, else hold; set wins over a simultaneous clear.
REQ-028 detect_add and write_enb_reg SHALL have no effect on counters, soft resets or flags.

Reset
REQ-029 On an edge with rst=0: addr_reg=00, all cnt_n=0, all soft_reset_n=0, timeout_flag=000; this SHALL override every other update, including mid-count.
REQ-030 After reset, write_enb=000 until write_enb_reg=1; fifo_full=full_0; vld_out_n follows ~empty_n immediately.

Verification
REQ-031 detect_add=1 with data_in=10, then write_enb_reg=1 -> write_enb=100; with full_2=1, fifo_full=1 and full_0/full_1 ignored.
REQ-032 data_in=11 latched, write_enb_reg=1 and full_0..2=111 -> write_enb=000, fifo_full=0.
REQ-033 empty_1=0, read_enb_1=0 for 30 cycles -> soft_reset_1 high for exactly cycle 31, timeout_flag=010; soft_reset_0 and soft_reset_2 stay 0.
REQ-034 Same as REQ-033 but read_enb_1=1 on cycle 30 -> no pulse, cnt_1=0, timeout_flag=000.
REQ-035 Ports 0 and 2 both held valid and unread 30 cycles -> both pulse in cycle 31; clr_flags=1 on that same edge -> timeout_flag=101; clr_flags=1 one cycle later -> 000.
REQ-036 rst=0 asserted at cnt_0=20 -> cnt_0=0, no pulse; valid and unread afterwards -> pulse only after a further 30 cycles.
